eva_ahb_slv_mem: RTL and testbench



---
 rtl/eva_ahb_slv_mem.sv | 200 ++++++++++++++++++++
 tb/tb_eva_ahb_slv_mem.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eva_ahb_slv_mem.sv
// AHB-Lite responder: 2^ADDR_W x 32-bit register memory with programmable OKAY wait states,
// two-cycle ERROR responses and a doorbell word whose low byte drives the intr level.
module eva_ahb_slv_mem #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WAIT_CYC  = 0
) (
    input  logic        hclk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic [7:0]  intr
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Illegal size, misaligned byte address, or outside this slave's window.
    function automatic logic addr_err(input logic [31:0] addr, input logic [2:0] size);
        addr_err = (size != 3'b010) || (addr[1:0] != 2'b00) ||
                   (addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_s;
    logic                wr_r;
    logic                err_r;
    logic [ADDR_W-1:0]   idx_r;
    logic [31:0]         mem_r [DEPTH];
    logic                hreadyout_r;
    logic [1:0]          hresp_r;
    logic [31:0]         hrdata_r;
    logic [7:0]          intr_r;

    logic                slot_s;
    logic                active_s;
    logic                accept_s;
    logic                err_s;
    logic [ADDR_W-1:0]   aidx_s;
    logic                commit_s;
    logic                fwd_s;
    logic                ready_s;
    logic [1:0]          resp_s;
    logic [31:0]         hrdata_s;

    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;
    assign hrdata    = hrdata_r;
    assign intr      = intr_r;

    // Address-phase decode: a new transfer is only taken while this slave is not stalling.
    always_comb begin
        slot_s   = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR2);
        active_s = (htrans == 2'b10) || (htrans == 2'b11);
        accept_s = hsel && active_s && hready && slot_s;
        err_s    = addr_err(haddr, hsize);
        aidx_s   = haddr[ADDR_W+1:2];
        commit_s = (state_r == ST_DONE) && wr_r && !err_r;
        fwd_s    = commit_s && (idx_r == aidx_s);
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_DONE;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_ERR1: begin
                state_s = ST_ERR2;
            end
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (!accept_s) begin
                    state_s = ST_IDLE;
                end else if (err_s) begin
                    state_s = ST_ERR1;
                end else if (WAIT_INIT == 4'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = WAIT_INIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Response decode of the upcoming state, so the response pins come straight from flops.
    always_comb begin
        ready_s = 1'b1;
        resp_s  = RESP_OKAY;
        case (state_s)
            ST_IDLE: begin ready_s = 1'b1; resp_s = RESP_OKAY; end
            ST_WAIT: begin ready_s = 1'b0; resp_s = RESP_OKAY; end
            ST_DONE: begin ready_s = 1'b1; resp_s = RESP_OKAY; end
            ST_ERR1: begin ready_s = 1'b0; resp_s = RESP_ERR;  end
            ST_ERR2: begin ready_s = 1'b1; resp_s = RESP_ERR;  end
            default: begin ready_s = 1'b1; resp_s = RESP_OKAY; end
        endcase
    end

    // Read data for the upcoming DONE cycle; zero-wait reads may hit the write being committed.
    always_comb begin
        hrdata_s = hrdata_r;
        if (accept_s && !err_s && !hwrite && (WAIT_INIT == 4'd0)) begin
            if (fwd_s) begin
                hrdata_s = hwdata;
            end else begin
                hrdata_s = mem_r[aidx_s];
            end
        end else if ((state_r == ST_WAIT) && (state_s == ST_DONE) && !wr_r) begin
            hrdata_s = mem_r[idx_r];
        end else if (state_s == ST_ERR1) begin
            hrdata_s = 32'h0000_0000;
        end else begin
            hrdata_s = hrdata_r;
        end
    end

    // Control state, captured transfer attributes and registered bus outputs.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            wr_r        <= 1'b0;
            err_r       <= 1'b0;
            idx_r       <= '0;
            hreadyout_r <= 1'b1;
            hresp_r     <= RESP_OKAY;
            hrdata_r    <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            hreadyout_r <= ready_s;
            hresp_r     <= resp_s;
            hrdata_r    <= hrdata_s;
            if (accept_s) begin
                wr_r  <= hwrite;
                err_r <= err_s;
                idx_r <= aidx_s;
            end else begin
                wr_r  <= wr_r;
                err_r <= err_r;
                idx_r <= idx_r;
            end
        end
    end

    // Storage array: commits at the edge that closes a write's DONE cycle.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (commit_s) begin
            mem_r[idx_r] <= hwdata;
        end else begin
            mem_r[idx_r] <= mem_r[idx_r];
        end
    end

    // Doorbell level lags the storage word by one cycle.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            intr_r <= 8'h00;
        end else begin
            intr_r <= mem_r[DEPTH-1][7:0];
        end
    end

endmodule

// File: tb/tb_eva_ahb_slv_mem.sv
// Directed bench for eva_ahb_slv_mem: three instances (0, 3 and 5 wait states) share the
// address/data bus and are addressed individually through their own hsel.
module tb_eva_ahb_slv_mem;
    logic        hclk;
    logic        rst_n;
    logic        hsel0, hsel3, hsel5;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        rdy0, rdy3, rdy5;
    logic [1:0]  resp0, resp3, resp5;
    logic [31:0] rdata0, rdata3, rdata5;
    logic [7:0]  intr0, intr3, intr5;

    int nvec = 0;
    int nmis = 0;

    logic [31:0] rd;
    int          w;
    logic [1:0]  rf, rl;

    eva_ahb_slv_mem #(.ADDR_W(6), .BASE_ADDR(32'h0000_0000), .WAIT_CYC(0)) u_w0 (
        .hclk(hclk), .rst_n(rst_n), .hsel(hsel0), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(rdy0), .hresp(resp0), .hrdata(rdata0), .intr(intr0));

    eva_ahb_slv_mem #(.ADDR_W(6), .BASE_ADDR(32'h0000_0000), .WAIT_CYC(3)) u_w3 (
        .hclk(hclk), .rst_n(rst_n), .hsel(hsel3), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(rdy3), .hresp(resp3), .hrdata(rdata3), .intr(intr3));

    eva_ahb_slv_mem #(.ADDR_W(6), .BASE_ADDR(32'h0000_0000), .WAIT_CYC(5)) u_w5 (
        .hclk(hclk), .rst_n(rst_n), .hsel(hsel5), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(rdy5), .hresp(resp5), .hrdata(rdata5), .intr(intr5));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    function automatic logic get_rdy(input int k);
        case (k)
            0:       return rdy0;
            3:       return rdy3;
            default: return rdy5;
        endcase
    endfunction

    function automatic logic [1:0] get_resp(input int k);
        case (k)
            0:       return resp0;
            3:       return resp3;
            default: return resp5;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int k);
        case (k)
            0:       return rdata0;
            3:       return rdata3;
            default: return rdata5;
        endcase
    endfunction

    task automatic set_sel(input int k, input logic v);
        hsel0 = 1'b0;
        hsel3 = 1'b0;
        hsel5 = 1'b0;
        case (k)
            0:       hsel0 = v;
            3:       hsel3 = v;
            default: hsel5 = v;
        endcase
    endtask

    // One non-pipelined transfer; returns read data and response seen in the last data-phase cycle.
    task automatic do_xfer(input int k, input logic wr, input logic [31:0] addr,
                           input logic [2:0] sz, input logic [31:0] wd,
                           output logic [31:0] rdo, output int waits,
                           output logic [1:0] resp_first, output logic [1:0] resp_last);
        logic done;
        set_sel(k, 1'b1);
        htrans = 2'b10;
        hwrite = wr;
        haddr  = addr;
        hsize  = sz;
        cyc();
        set_sel(k, 1'b0);
        htrans     = 2'b00;
        hwdata     = wd;
        waits      = 0;
        done       = 1'b0;
        rdo        = 32'h0;
        resp_last  = 2'b11;
        resp_first = get_resp(k);
        for (int i = 0; i < 40 && !done; i++) begin
            if (get_rdy(k)) begin
                rdo       = get_rdata(k);
                resp_last = get_resp(k);
                done      = 1'b1;
            end else begin
                waits++;
                cyc();
            end
        end
        check("xfer_done", {31'h0, done}, 32'h1);
        cyc();
    endtask

    initial begin
        rst_n  = 1'b0;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        hsel5  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hsize  = 3'b010;
        hwdata = 32'h0;
        hready = 1'b1;
        cyc();
        cyc();
        check("rst_ready", {31'h0, rdy0}, 32'h1);
        check("rst_resp", {30'h0, resp0}, 32'h0);
        check("rst_rdata", rdata0, 32'h0);
        check("rst_intr", {24'h0, intr0}, 32'h0);
        check("rst_ready_w3", {31'h0, rdy3}, 32'h1);
        rst_n = 1'b1;
        cyc();

        // Back-to-back write then read of 0x10 on the zero-wait slave (read forwarded).
        hsel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'b010;
        check("b2b_t0_ready", {31'h0, rdy0}, 32'h1);
        cyc();
        hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
        check("b2b_wdone_ready", {31'h0, rdy0}, 32'h1);
        check("b2b_wdone_resp", {30'h0, resp0}, 32'h0);
        cyc();
        hsel0 = 1'b0; htrans = 2'b00;
        check("b2b_rdone_ready", {31'h0, rdy0}, 32'h1);
        check("b2b_rdone_resp", {30'h0, resp0}, 32'h0);
        check("b2b_fwd_rdata", rdata0, 32'hDEAD_BEEF);
        cyc();
        check("b2b_idle_ready", {31'h0, rdy0}, 32'h1);

        // Three wait states.
        do_xfer(3, 1'b1, 32'h04, 3'b010, 32'h1234_5678, rd, w, rf, rl);
        check("w3_wr_waits", w, 32'd3);
        check("w3_wr_resp", {30'h0, rl}, 32'h0);
        do_xfer(3, 1'b0, 32'h04, 3'b010, 32'h0, rd, w, rf, rl);
        check("w3_rd_waits", w, 32'd3);
        check("w3_rd_data", rd, 32'h1234_5678);

        // Error responses; word 0 must survive.
        do_xfer(3, 1'b1, 32'h00, 3'b010, 32'hA5A5_0000, rd, w, rf, rl);
        check("w3_w0_waits", w, 32'd3);
        do_xfer(3, 1'b0, 32'h0000_0102, 3'b010, 32'h0, rd, w, rf, rl);
        check("err_unal_resp1", {30'h0, rf}, 32'h1);
        check("err_unal_waits", w, 32'd1);
        check("err_unal_resp2", {30'h0, rl}, 32'h1);
        check("err_unal_rdata", rd, 32'h0);
        do_xfer(3, 1'b1, 32'h0000_0000, 3'b000, 32'h0000_0BAD, rd, w, rf, rl);
        check("err_size_resp1", {30'h0, rf}, 32'h1);
        check("err_size_waits", w, 32'd1);
        check("err_size_resp2", {30'h0, rl}, 32'h1);
        do_xfer(3, 1'b1, 32'h0000_0100, 3'b010, 32'h0000_0BAD, rd, w, rf, rl);
        check("err_win_resp1", {30'h0, rf}, 32'h1);
        check("err_win_waits", w, 32'd1);
        check("err_win_resp2", {30'h0, rl}, 32'h1);
        do_xfer(3, 1'b0, 32'h00, 3'b010, 32'h0, rd, w, rf, rl);
        check("err_w0_intact", rd, 32'hA5A5_0000);
        check("err_w0_resp", {30'h0, rl}, 32'h0);

        // Doorbell at the top word.
        do_xfer(0, 1'b1, 32'hFC, 3'b010, 32'h0000_0081, rd, w, rf, rl);
        check("db_intr_at_commit", {24'h0, intr0}, 32'h0);
        cyc();
        check("db_intr_set", {24'h0, intr0}, 32'h81);
        do_xfer(0, 1'b0, 32'hFC, 3'b010, 32'h0, rd, w, rf, rl);
        check("db_read", rd, 32'h81);
        check("db_read_waits", w, 32'd0);
        do_xfer(0, 1'b1, 32'hFC, 3'b010, 32'h0, rd, w, rf, rl);
        cyc();
        check("db_intr_clr", {24'h0, intr0}, 32'h0);

        // IDLE, BUSY, unselected and hready-stalled address phases never access memory.
        hwrite = 1'b1; haddr = 32'h10; hsize = 3'b010;
        for (int v = 0; v < 4; v++) begin
            hsel0  = (v != 2);
            htrans = (v == 0) ? 2'b00 : ((v == 1) ? 2'b01 : 2'b10);
            hready = (v != 3);
            hwdata = $urandom;
            cyc();
            check($sformatf("noacc%0d_ready", v), {31'h0, rdy0}, 32'h1);
            check($sformatf("noacc%0d_resp", v), {30'h0, resp0}, 32'h0);
        end
        hsel0 = 1'b0; htrans = 2'b00; hready = 1'b1; hwdata = $urandom;
        cyc();
        do_xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, w, rf, rl);
        check("noacc_mem_intact", rd, 32'hDEAD_BEEF);

        // Five wait states, then reset during a write's wait phase.
        do_xfer(5, 1'b1, 32'h0C, 3'b010, 32'h5555_AAAA, rd, w, rf, rl);
        check("w5_wr_waits", w, 32'd5);
        do_xfer(5, 1'b0, 32'h0C, 3'b010, 32'h0, rd, w, rf, rl);
        check("w5_rd_waits", w, 32'd5);
        check("w5_rd_data", rd, 32'h5555_AAAA);
        hsel5 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h08; hsize = 3'b010;
        cyc();
        hsel5 = 1'b0; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
        check("mid_wait1", {31'h0, rdy5}, 32'h0);
        cyc();
        check("mid_wait2", {31'h0, rdy5}, 32'h0);
        rst_n = 1'b0;
        cyc();
        check("mid_rst_ready", {31'h0, rdy5}, 32'h1);
        check("mid_rst_resp", {30'h0, resp5}, 32'h0);
        check("mid_rst_rdata", rdata5, 32'h0);
        check("mid_rst_rdata_w0", rdata0, 32'h0);
        rst_n = 1'b1;
        cyc();
        check("post_rst_idle", {31'h0, rdy5}, 32'h1);
        do_xfer(5, 1'b0, 32'h08, 3'b010, 32'h0, rd, w, rf, rl);
        check("post_rst_waits", w, 32'd5);
        check("post_rst_no_write", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
